mat_result_serializer: RTL and testbench
========================================

Name: mat_result_serializer

Overview:
- Downstream stage of mat_mult_2x2. Captures each 2x2 result (w, x, y, z) on the cycle `done` is high and buffers it in a small FIFO.
- Emits the buffered results one element per beat on a valid/ready stream, in order w, x, y, z.
- Sustains bursts from the 1-matrix/cycle multiplier up to FIFO depth; excess results are dropped and flagged.

Parameters:
- DW, 32: element width; must equal the multiplier output width.
- DEPTH, 4: FIFO depth in matrices; power of 2, minimum 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  connect to mat_mult_2x2 `done`; one matrix offered per high cycle.
- in_w, in_x, in_y, in_z  input  DW each  signed result elements.
- m_data  output  DW  signed current element.
- m_valid  output  1  m_data valid.
- m_ready  input  1  consumer accepts beat when m_valid && m_ready.
- m_idx  output  2  element index: 0=w, 1=x, 2=y, 3=z.
- m_first  output  1  high when m_idx==0.
- m_last  output  1  high when m_idx==3.
- fifo_level  output  $clog2(DEPTH)+1  number of matrices stored (excludes the one being sent).
- fifo_full  output  1  fifo_level==DEPTH.
- overflow  output  1  sticky; set when a matrix is dropped; cleared only by reset.

Behaviour:
- Reset values: m_valid=0, m_data=0, m_idx=0, fifo_level=0, fifo_full=0, overflow=0. FSM goes to IDLE; FIFO pointers cleared.
- Reset mid-operation: a partially sent matrix and all buffered entries are discarded. No further beats are emitted for them.
- Push: in_valid is accepted when !fifo_full, or when fifo_full and a pop occurs in the same cycle.
  - Otherwise the matrix is dropped and overflow is set on the next edge.
  - FIFO contents are never corrupted.
- FIFO entry: {in_w, in_x, in_y, in_z}, 4*DW bits, stored unmodified (no truncation or sign change).
- FSM states:
  - IDLE: m_valid=0. If fifo_level>0: pop into the hold register, set m_idx=0, go to SEND.
  - SEND: m_valid=1, m_data=hold[m_idx].
    - On handshake with m_idx<3: m_idx increments.
    - On handshake with m_idx==3 and fifo_level>0: pop, m_idx=0, stay in SEND (no bubble between matrices).
    - On handshake with m_idx==3 and fifo_level==0: go to IDLE.
- Latency: in_valid sampled at edge N into an empty, idle block gives m_valid=1 with w after edge N+1. There is no combinational in-to-out path.
- Stability: while m_valid && !m_ready, m_data, m_idx, m_first and m_last hold stable.
- Throughput: 4 beats per matrix at m_ready=1.
- Burst capacity: with the FSM idle and FIFO empty, a burst of DEPTH+1 consecutive in_valid cycles is lossless (one entry pops into the hold register). Longer bursts drop.
- Simultaneous push and pop at fifo_level==DEPTH: both occur; level is unchanged.
- Pointer wrap: natural modulo DEPTH; level is computed from extended pointers.

Optional Feature:
- Macro MATSER_STATS_EN.
- Defined: adds two 16-bit outputs, both reset to 0 and saturating at 16'hFFFF (no wrap):
  - mat_sent_cnt: increments on the m_last handshake.
  - mat_drop_cnt: increments per dropped matrix.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mat_ser_pkg:
  - DW default constant.
  - Element-index localparams IDX_W/IDX_X/IDX_Y/IDX_Z.
  - FSM state encoding (IDLE, SEND).
- Sub-module mat_ser_fifo: parameterised synchronous FIFO (width 4*DW, DEPTH) providing push, pop, level and full. The serializer FSM lives in the top module.

Test Plan:
- Single matrix: w=19, x=22, y=43, z=50 (product of [1 2;3 4] and [5 6;7 8]), m_ready=1.
  - Expect beats 19, 22, 43, 50 on consecutive cycles, m_idx 0..3, m_first on beat 0, m_last on beat 3, first beat one cycle after in_valid.
- Backpressure: same input, m_ready toggled 1,0,0,1,0,1,1.
  - Expect exactly 4 accepted beats in order; m_data held during stalls; no duplicates.
- Back-to-back: 5 matrices on consecutive cycles into the idle block (DEPTH=4), m_ready=1.
  - Expect 20 beats with no gaps between matrices; overflow=0.
- Overflow: 7 consecutive matrices with m_ready=0.
  - Expect the first 5 retained; overflow=1 from the cycle after the 6th push; output order intact after release.
  - With MATSER_STATS_EN: mat_drop_cnt=2, then mat_sent_cnt=5.
- Reset mid-burst: assert reset during the m_idx==2 beat with 2 matrices queued.
  - Expect m_valid=0, fifo_level=0, overflow=0 after the reset edge; a new matrix afterwards emits correctly from w.
- Random stream: 100 matrices from elements in −20..20, random in_valid and m_ready.
  - Every accepted matrix is emitted exactly once and matches a scoreboard; drops equal the overflow events.

Source files
------------

// File: rtl/mat_ser_pkg.sv
// Shared constants and types for the mat_mult_2x2 result serializer.
package mat_ser_pkg;

  // Default element width, matching the multiplier output width.
  localparam int DW_DEFAULT = 32;

  // Element index encoding on m_idx (row-major order of the 2x2 result).
  localparam logic [1:0] IDX_W = 2'd0;
  localparam logic [1:0] IDX_X = 2'd1;
  localparam logic [1:0] IDX_Y = 2'd2;
  localparam logic [1:0] IDX_Z = 2'd3;

  // Serializer FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/mat_ser_fifo.sv
// Synchronous FIFO holding whole 2x2 results ({w, x, y, z} per entry).
// Pointers carry one extra bit so the level is a plain difference and
// wrap naturally modulo DEPTH. Read data is the entry at the read pointer.
module mat_ser_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Advance the extended read/write pointers on accepted push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; a push into the slot being popped reads old data first.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));

endmodule

// File: rtl/mat_result_serializer.sv
// Captures 2x2 results from mat_mult_2x2 into a FIFO and streams them out
// one element per valid/ready beat in order w, x, y, z. Results arriving
// while the FIFO is full (and nothing pops) are dropped; overflow is sticky.
// Optional macro MATSER_STATS_EN adds saturating sent/dropped matrix counters.
module mat_result_serializer
  import mat_ser_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DW-1:0]           in_w,
  input  logic [DW-1:0]           in_x,
  input  logic [DW-1:0]           in_y,
  input  logic [DW-1:0]           in_z,
  output logic [DW-1:0]           m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [1:0]              m_idx,
  output logic                    m_first,
  output logic                    m_last,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    fifo_full,
`ifdef MATSER_STATS_EN
  output logic [15:0]             mat_sent_cnt,
  output logic [15:0]             mat_drop_cnt,
`endif
  output logic                    overflow
);

  ser_state_t        state;
  logic [4*DW-1:0]   hold;
  logic [4*DW-1:0]   fifo_dout;
  logic              push;
  logic              pop;
  logic              drop;
  logic              hs_last;

  // Select one element of a packed {w, x, y, z} result.
  function automatic logic [DW-1:0] elem(input logic [4*DW-1:0] m, input logic [1:0] i);
    case (i)
      IDX_W:   elem = m[4*DW-1 -: DW];
      IDX_X:   elem = m[3*DW-1 -: DW];
      IDX_Y:   elem = m[2*DW-1 -: DW];
      IDX_Z:   elem = m[DW-1:0];
      default: elem = m[DW-1:0];
    endcase
  endfunction

  mat_ser_fifo #(
    .W     (4*DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({in_w, in_x, in_y, in_z}),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full)
  );

  // Decide this cycle's pop (hold reload), push and drop.
  always_comb begin
    hs_last = (state == SEND) && m_ready && (m_idx == IDX_Z);
    if (state == IDLE) begin
      pop = |fifo_level;
    end else begin
      pop = hs_last && (|fifo_level);
    end
    if (in_valid) begin
      push = !fifo_full || pop;
      drop = fifo_full && !pop;
    end else begin
      push = 1'b0;
      drop = 1'b0;
    end
  end

  // Serializer FSM with registered stream outputs and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold     <= {(4*DW){1'b0}};
      m_valid  <= 1'b0;
      m_data   <= {DW{1'b0}};
      m_idx    <= IDX_W;
      m_first  <= 1'b1;
      m_last   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            hold    <= fifo_dout;
            m_data  <= elem(fifo_dout, IDX_W);
            m_idx   <= IDX_W;
            m_first <= 1'b1;
            m_last  <= 1'b0;
            m_valid <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (m_ready) begin
            if (m_idx != IDX_Z) begin
              m_idx   <= m_idx + 2'd1;
              m_data  <= elem(hold, m_idx + 2'd1);
              m_first <= 1'b0;
              m_last  <= (m_idx == IDX_Y);
            end else if (pop) begin
              // Next matrix follows immediately, no bubble.
              hold    <= fifo_dout;
              m_data  <= elem(fifo_dout, IDX_W);
              m_idx   <= IDX_W;
              m_first <= 1'b1;
              m_last  <= 1'b0;
            end else begin
              m_valid <= 1'b0;
              m_idx   <= IDX_W;
              m_first <= 1'b1;
              m_last  <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MATSER_STATS_EN
  // Saturating counts of completed and dropped matrices.
  always_ff @(posedge clk) begin
    if (reset) begin
      mat_sent_cnt <= 16'h0000;
      mat_drop_cnt <= 16'h0000;
    end else begin
      if (hs_last && (mat_sent_cnt != 16'hFFFF)) mat_sent_cnt <= mat_sent_cnt + 16'd1;
      if (drop && (mat_drop_cnt != 16'hFFFF))    mat_drop_cnt <= mat_drop_cnt + 16'd1;
    end
  end
`else
  // Default build: no statistics ports or counters.
`endif

endmodule

// File: tb/tb_mat_result_serializer.sv
// Self-checking bench for mat_result_serializer: constant vector tables,
// hand-written corner sequences, and a random stream against a queue model.
module tb_mat_result_serializer;
  import mat_ser_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef logic [DW-1:0]        elem_t;
  typedef logic [0:3][DW-1:0]   mat_t;

  typedef struct {
    logic  rst;
    logic  iv;
    mat_t  m;
    logic  rdy;
    logic  ev;
    elem_t ed;
    logic [1:0] ei;
    logic  ef;
    logic  el;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  elem_t in_w = '0, in_x = '0, in_y = '0, in_z = '0;
  logic m_ready = 1'b0;
  elem_t m_data;
  logic m_valid, m_first, m_last, fifo_full, overflow;
  logic [1:0] m_idx;
  logic [LW-1:0] fifo_level;
`ifdef MATSER_STATS_EN
  logic [15:0] mat_sent_cnt, mat_drop_cnt;
`endif

  always #5 clk = ~clk;

  mat_result_serializer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_w(in_w), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_idx(m_idx), .m_first(m_first), .m_last(m_last),
    .fifo_level(fifo_level), .fifo_full(fifo_full),
`ifdef MATSER_STATS_EN
    .mat_sent_cnt(mat_sent_cnt), .mat_drop_cnt(mat_drop_cnt),
`endif
    .overflow(overflow)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference model: stored matrices, beats of the matrix being sent.
  mat_t  mq[$];
  elem_t mb[$];
  logic  ov_m = 1'b0;
  int    drops_m = 0;
  int    sent_m = 0;
  elem_t acc[$];   // elements of every accepted matrix, in order
  elem_t got[$];   // beats actually handed over by the DUT
  int    gotc[$];  // cycle of each handed-over beat

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: drive inputs, record handshakes, advance model, compare at negedge.
  task automatic step(input logic rst, input logic iv, input mat_t m, input logic rdy);
    bit hs, pop, push_ok;
    mat_t t;
    reset = rst; in_valid = iv; m_ready = rdy;
    in_w = m[0]; in_x = m[1]; in_y = m[2]; in_z = m[3];
    if (!rst && m_valid && m_ready) begin
      got.push_back(m_data);
      gotc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete(); mb.delete(); acc.delete(); got.delete(); gotc.delete();
      ov_m = 1'b0; drops_m = 0; sent_m = 0;
    end else begin
      hs = (mb.size() > 0) && rdy;
      pop = (mq.size() > 0) && ((mb.size() == 0) || (hs && mb.size() == 1));
      push_ok = iv && ((mq.size() < DEPTH) || pop);
      if (hs) begin
        if (mb.size() == 1 && sent_m < 65535) sent_m++;
        void'(mb.pop_front());
      end
      if (pop) begin
        t = mq.pop_front();
        for (int k = 0; k < 4; k++) mb.push_back(t[k]);
      end
      if (push_ok) begin
        mq.push_back(m);
        for (int k = 0; k < 4; k++) acc.push_back(m[k]);
      end else if (iv) begin
        if (drops_m < 65535) drops_m++;
        ov_m = 1'b1;
      end
    end
    @(negedge clk);
    chk("m_valid", m_valid, mb.size() > 0);
    chk("fifo_level", fifo_level, mq.size());
    chk("fifo_full", fifo_full, mq.size() == DEPTH);
    chk("overflow", overflow, ov_m);
    if (mb.size() > 0) begin
      chk("m_data", m_data, mb[0]);
      chk("m_idx", m_idx, 4 - mb.size());
      chk("m_first", m_first, mb.size() == 4);
      chk("m_last", m_last, mb.size() == 1);
    end
`ifdef MATSER_STATS_EN
    chk("mat_sent_cnt", mat_sent_cnt, sent_m);
    chk("mat_drop_cnt", mat_drop_cnt, drops_m);
`endif
  endtask

  function automatic mat_t mk(input int k);
    mat_t r;
    for (int e = 0; e < 4; e++) r[e] = elem_t'(k * 16 + e + 1);
    return r;
  endfunction

  function automatic vec_t v(input logic rst, input logic iv, input mat_t m, input logic rdy,
                             input logic ev, input int ed, input logic [1:0] ei,
                             input logic ef, input logic el);
    vec_t r;
    r.rst = rst; r.iv = iv; r.m = m; r.rdy = rdy;
    r.ev = ev; r.ed = elem_t'(ed); r.ei = ei; r.ef = ef; r.el = el;
    return r;
  endfunction

  initial begin
    vec_t tbl[$];
    mat_t mm, zz, ma, mb4, mc, md;
    int offered, r, gsz;

    zz = '0;
    mm[0] = 32'd19; mm[1] = 32'd22; mm[2] = 32'd43; mm[3] = 32'd50;

    // Single matrix at full rate, then backpressure pattern 1,0,0,1,0,1,1.
    tbl.push_back(v(1, 0, zz, 0, 0,  0, 2'd0, 0, 0));
    tbl.push_back(v(0, 1, mm, 1, 0,  0, 2'd0, 0, 0));
    tbl.push_back(v(0, 0, zz, 1, 1, 19, 2'd0, 1, 0));
    tbl.push_back(v(0, 0, zz, 1, 1, 22, 2'd1, 0, 0));
    tbl.push_back(v(0, 0, zz, 1, 1, 43, 2'd2, 0, 0));
    tbl.push_back(v(0, 0, zz, 1, 1, 50, 2'd3, 0, 1));
    tbl.push_back(v(0, 0, zz, 1, 0,  0, 2'd0, 0, 0));
    tbl.push_back(v(1, 0, zz, 0, 0,  0, 2'd0, 0, 0));
    tbl.push_back(v(0, 1, mm, 1, 0,  0, 2'd0, 0, 0));
    tbl.push_back(v(0, 0, zz, 1, 1, 19, 2'd0, 1, 0));
    tbl.push_back(v(0, 0, zz, 1, 1, 22, 2'd1, 0, 0));
    tbl.push_back(v(0, 0, zz, 0, 1, 22, 2'd1, 0, 0));
    tbl.push_back(v(0, 0, zz, 0, 1, 22, 2'd1, 0, 0));
    tbl.push_back(v(0, 0, zz, 1, 1, 43, 2'd2, 0, 0));
    tbl.push_back(v(0, 0, zz, 0, 1, 43, 2'd2, 0, 0));
    tbl.push_back(v(0, 0, zz, 1, 1, 50, 2'd3, 0, 1));
    tbl.push_back(v(0, 0, zz, 1, 0,  0, 2'd0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].iv, tbl[i].m, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), m_data, tbl[i].ed);
        chk($sformatf("tbl%0d_idx", i), m_idx, tbl[i].ei);
        chk($sformatf("tbl%0d_first", i), m_first, tbl[i].ef);
        chk($sformatf("tbl%0d_last", i), m_last, tbl[i].el);
      end
    end
    gsz = got.size();
    chk("bp_beat_count", gsz, 4);
    for (int i = 0; i < 4 && i < gsz; i++) chk($sformatf("bp_beat%0d", i), got[i], mm[i]);

    // Back-to-back: 5 matrices on consecutive cycles, no gaps expected.
    step(1, 0, zz, 0);
    for (int k = 0; k < 5; k++) step(0, 1, mk(k), 1);
    for (int c = 0; c < 30; c++) step(0, 0, zz, 1);
    gsz = got.size();
    chk("b2b_beat_count", gsz, 20);
    if (gsz == 20) chk("b2b_no_gaps", gotc[19] - gotc[0], 19);
    for (int i = 0; i < 20 && i < gsz; i++) begin
      mm = mk(i / 4);
      chk($sformatf("b2b_beat%0d", i), got[i], mm[i % 4]);
    end
    chk("b2b_overflow", overflow, 1'b0);

    // Overflow: 7 matrices with the consumer stalled.
    step(1, 0, zz, 0);
    for (int k = 0; k < 7; k++) begin
      step(0, 1, mk(10 + k), 0);
      chk($sformatf("ovf_after_push%0d", k), overflow, k >= 5);
    end
`ifdef MATSER_STATS_EN
    chk("ovf_drop_cnt", mat_drop_cnt, 16'd2);
`endif
    for (int c = 0; c < 40; c++) step(0, 0, zz, 1);
    gsz = got.size();
    chk("ovf_beat_count", gsz, 20);
    for (int i = 0; i < 20 && i < gsz; i++) begin
      mm = mk(10 + i / 4);
      chk($sformatf("ovf_beat%0d", i), got[i], mm[i % 4]);
    end
`ifdef MATSER_STATS_EN
    chk("ovf_sent_cnt", mat_sent_cnt, 16'd5);
`endif

    // Reset mid-burst (overflow still set from the previous test).
    ma = mk(20); mb4 = mk(21); mc = mk(22); md = mk(23);
    step(0, 1, ma, 1);
    step(0, 1, mb4, 1);
    step(0, 1, mc, 1);
    step(0, 0, zz, 1);
    chk("rst_pre_idx", m_idx, 2'd2);
    chk("rst_pre_level", fifo_level, 2);
    chk("rst_pre_overflow", overflow, 1'b1);
    step(1, 0, zz, 0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 1'b0);
    step(0, 1, md, 1);
    for (int c = 0; c < 12; c++) step(0, 0, zz, 1);
    gsz = got.size();
    chk("rst_new_beat_count", gsz, 4);
    for (int i = 0; i < 4 && i < gsz; i++) chk($sformatf("rst_new_beat%0d", i), got[i], md[i]);

    // Random stream of 100 matrices with random valid/ready.
    step(1, 0, zz, 0);
    offered = 0;
    for (int c = 0; c < 5000 && offered < 100; c++) begin
      if ($urandom_range(0, 99) < 35) begin
        for (int e = 0; e < 4; e++) begin
          r = int'($urandom_range(0, 40));
          mm[e] = elem_t'(r - 20);
        end
        offered++;
        step(0, 1, mm, $urandom_range(0, 99) < 70);
      end else begin
        step(0, 0, zz, $urandom_range(0, 99) < 70);
      end
    end
    chk("rnd_offered", offered, 100);
    for (int c = 0; c < 800 && (mq.size() > 0 || mb.size() > 0); c++) step(0, 0, zz, 1);
    step(0, 0, zz, 1);
    chk("rnd_drained_valid", m_valid, 1'b0);
    chk("rnd_beat_count", got.size(), acc.size());
    for (int i = 0; i < acc.size() && i < got.size(); i++)
      chk($sformatf("rnd_beat%0d", i), got[i], acc[i]);
    chk("rnd_overflow_vs_drops", overflow, drops_m > 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
